// File: rtl/imem_boot_ctrl.sv
// Boot-time instruction-memory loader: streams program words into IMEM,
// holds the core in reset until the last write settles, then lets it run.
module imem_boot_ctrl #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int REL_CYC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload_req,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          run,
  output logic          err,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {LOAD, RELEASE, RUN, ERR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [3:0]    rel_cnt;
  logic          hs;
  logic          reload_fire;

  assign hs          = ld_valid & ld_ready;
  assign reload_fire = reload_req & ((state == RUN) | (state == ERR));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    run        = 1'b0;
    err        = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_last)                              state_nxt = RELEASE;
          else if (wptr == AW'(DEPTH - 1))          state_nxt = ERR;
        end
      end
      RELEASE: begin
        // REL_CYC+1 cycles in total: one for the final write to land, then REL_CYC of hold.
        if (rel_cnt == 4'(REL_CYC)) state_nxt = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        run        = 1'b1;
        if (reload_req) state_nxt = LOAD;
      end
      ERR: begin
        err = 1'b1;
        if (reload_req) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      rel_cnt    <= '0;
    end else begin
      imem_we <= hs;
      if (hs) begin
        imem_waddr <= wptr;
        imem_wdata <= ld_data;
        wptr       <= wptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (reload_fire) begin
        wptr       <= '0;
        word_count <= '0;
      end
      if (state == RELEASE) rel_cnt <= rel_cnt + 1'b1;
      else                  rel_cnt <= '0;
    end
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter: DEPTH, 256, instruction-memory words; the loader never writes beyond this.
REQ-002 Parameter: AW, 8, write-address width; log2(DEPTH).
REQ-003 Parameter: REL_CYC, 2, cycles core_reset stays high after the load completes; valid range 1..15.
REQ-004 Port: clk, in, 1, single clock; all state changes on the posedge.
REQ-005 Port: reset_n, in, 1, synchronous active-low reset.
REQ-006 Port: ld_valid, in, 1, loader word present.
REQ-007 Port: ld_data, in, 32, instruction word.
REQ-008 Port: ld_last, in, 1, qualifies ld_valid; marks the final program word.
REQ-009 Port: ld_ready, out, 1, block accepts a word this cycle.
REQ-010 Port: reload_req, in, 1, request to halt the core and reload the program.
REQ-011 Port: imem_we, out, 1, instruction-memory write strobe.
REQ-012 Port: imem_waddr, out, AW, write word address.
REQ-013 Port: imem_wdata, out, 32, write data.
REQ-014 Port: core_reset, out, 1, active-high reset to the core's IF stage (PC to 0).
REQ-015 Port: run, out, 1, core is executing.
REQ-016 Port: err, out, 1, overflow: DEPTH words accepted without ld_last.
REQ-017 Port: word_count, out, AW+1, number of words written in the current load.

Function
REQ-018 States: LOAD, RELEASE, RUN, ERR; outputs ld_ready, core_reset, run and err are decoded from state only.
REQ-019 LOAD: ld_ready=1, core_reset=1, run=0, err=0.
REQ-020 A handshake occurs when ld_valid&ld_ready are both high at a posedge; ld_data and ld_last are ignored in any other cycle.
REQ-021 On a handshake the write port is registered and presented the next cycle: imem_we=1, imem_waddr=wptr, imem_wdata=ld_data; otherwise imem_we=0 and addr/data hold.
REQ-022 The wptr and word_count counters increment by 1 per handshake; wptr has no wrap-around, because the DEPTH-th handshake always leaves LOAD.
REQ-023 Handshake with ld_last=1 (wptr any value): go to RELEASE.
REQ-024 Handshake with ld_last=0 and wptr=DEPTH-1: the word is written, then go to ERR.
REQ-025 RELEASE: ld_ready=0, core_reset=1; a counter runs REL_CYC cycles, then the state goes to RUN; the final imem write therefore lands at least 1 cycle before core_reset falls.
REQ-026 RUN: ld_ready=0, core_reset=0, run=1; stays until reload_req.
REQ-027 ERR: ld_ready=0, core_reset=1, err=1, run=0; stays until reset or reload_req.
REQ-028 reload_req=1 in RUN or ERR: next state LOAD, wptr=0, word_count=0, err clears; core_reset rises on the same edge run falls.
REQ-029 reload_req in LOAD or RELEASE is ignored.
REQ-030 ld_valid outside LOAD is ignored, with no write and no counter change.
REQ-031 word_count holds its final value through RELEASE, RUN and ERR until the next LOAD entry.

Reset
REQ-032 reset_n=0 sampled at a posedge forces: state=LOAD, wptr=0, word_count=0, imem_we=0, imem_waddr=0, imem_wdata=0, REL counter=0.
REQ-033 Resulting output values: ld_ready=1, core_reset=1, run=0, err=0.
REQ-034 Reset has priority over all inputs, including a simultaneous handshake or reload_req.
REQ-035 Reset mid-load discards progress; already-written memory words are not cleared.

Verification
REQ-036 Load 3 words (0x00A00093, 0x00108113, 0x0000006F, last on third) -> writes at addr 0,1,2, each one cycle after its handshake; word_count=3; core_reset low exactly REL_CYC+1 cycles after the third handshake; run=1.
REQ-037 ld_valid toggling 1,0,1,1 with last on the fourth valid cycle -> exactly 3 writes, to addresses 0,1,2, no gaps in address; no write in the idle cycle.
REQ-038 256 words, ld_last=0 throughout -> 256 writes (addr 0..255); err=1, ld_ready=0, core_reset=1; a further ld_valid produces no write.
REQ-039 In RUN, reload_req pulse then 1-word load -> core_reset=1 next cycle, word_count returns to 0 then 1, write at addr 0, run returns.
REQ-040 reset_n low during load word 5 together with ld_valid=1 -> no write, all outputs at REQ-032/REQ-033 values; the next load restarts at addr 0.
REQ-041 ld_valid=1 and reload_req=1 held in RELEASE -> no write, RELEASE length unchanged, run=1 on schedule.
